// File: rtl/log_scale_search.sv
// log_scale_search: sequential inverse of the exponent-scale lookup.
// Walks an exponent k one step per cycle until T[k] <= x < T[k+1], where
// T[k] = round(256*e^k) for k = -5..2, then reports k, the residual and underflow.
// Optional feature macro: LOG_SCALE_REM_EN builds the residual subtractor and
// the out_rem register; without it out_rem is tied to zero.
module log_scale_search (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_scale,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_int,
    output logic [11:0] out_rem,
    output logic        out_uflow
);

    localparam int unsigned XW = 12;
    localparam int unsigned KW = 4;

    localparam logic signed [KW-1:0] K_MIN = -4'sd5;
    localparam logic signed [KW-1:0] K_MAX = 4'sd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_n;
    logic [XW-1:0]          x_q, x_n;
    logic signed [KW-1:0]   k_q, k_n;
    logic [KW-1:0]          out_int_n;
    logic                   out_uflow_n;
    logic                   in_ready_n;
    logic                   out_valid_n;
    logic [XW-1:0]          t_k;
    logic [XW-1:0]          t_k1;
    logic signed [KW-1:0]   k_inc;
    logic signed [KW-1:0]   k_dec;

    // Fixed threshold table indexed by the two's complement exponent.
    function automatic logic [XW-1:0] thr(input logic [KW-1:0] kk);
        logic [XW-1:0] t;
        case (kk)
            4'hB:    t = 12'd2;
            4'hC:    t = 12'd5;
            4'hD:    t = 12'd13;
            4'hE:    t = 12'd35;
            4'hF:    t = 12'd94;
            4'h0:    t = 12'd256;
            4'h1:    t = 12'd696;
            4'h2:    t = 12'd1892;
            default: t = 12'd0;
        endcase
        return t;
    endfunction

    assign k_inc = k_q + 4'sd1;
    assign k_dec = k_q - 4'sd1;
    assign t_k   = thr(KW'(k_q));
    assign t_k1  = thr(KW'(k_inc));

    // State, operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            k_q       <= '0;
            out_int   <= '0;
            out_uflow <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_n;
            x_q       <= x_n;
            k_q       <= k_n;
            out_int   <= out_int_n;
            out_uflow <= out_uflow_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
        end
    end

    // Next-state and next-value logic for the threshold walk.
    always_comb begin
        state_n     = state_q;
        x_n         = x_q;
        k_n         = k_q;
        out_int_n   = out_int;
        out_uflow_n = out_uflow;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_n     = in_scale;
                    k_n     = '0;
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                if ((k_q < K_MAX) && (x_q >= t_k1)) begin
                    k_n = k_inc;
                end else if ((k_q > K_MIN) && (x_q < t_k)) begin
                    k_n = k_dec;
                end else begin
                    out_int_n   = KW'(k_q);
                    out_uflow_n = (x_q < 12'd2);
                    state_n     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        in_ready_n  = (state_n == IDLE);
        out_valid_n = (state_n == DONE);
    end

`ifdef LOG_SCALE_REM_EN
    logic [XW-1:0] out_rem_q;
    logic [XW-1:0] out_rem_n;

    // Residual is captured together with the exponent; zero on underflow.
    always_comb begin
        out_rem_n = out_rem_q;
        if ((state_q == SEARCH) && (state_n == DONE)) begin
            out_rem_n = (x_q < 12'd2) ? '0 : XW'(x_q - t_k);
        end
    end

    // Residual output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rem_q <= '0;
        end else begin
            out_rem_q <= out_rem_n;
        end
    end

    assign out_rem = out_rem_q;
`else
    assign out_rem = 12'd0;
`endif

endmodule

// File: tb/tb_log_scale_search.sv
// Directed self-checking bench for log_scale_search.
// Residual expectations follow LOG_SCALE_REM_EN: zero when the macro is undefined.
module tb_log_scale_search;

`ifdef LOG_SCALE_REM_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_scale;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_int;
    logic [11:0] out_rem;
    logic        out_uflow;

    int total;
    int bad;

    log_scale_search dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_scale  (in_scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .out_rem   (out_rem),
        .out_uflow (out_uflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_int !== 4'd0) begin bad++; $display("FAIL reset_out_int got=%h want=0", out_int); end
        total++; if (out_rem !== 12'd0) begin bad++; $display("FAIL reset_out_rem got=%0d want=0", out_rem); end
        total++; if (out_uflow !== 1'b0) begin bad++; $display("FAIL reset_out_uflow got=%b want=0", out_uflow); end
    endtask

    // Table of single transactions with out_ready held high.
    task automatic test_lookup();
        int          xs   [11] = '{256, 1892, 4095, 695, 94, 93, 2, 0, 1, 5, 1891};
        int          ks   [11] = '{0, 2, 2, 0, -1, -2, -5, -5, -5, -4, 1};
        int          rems [11] = '{0, 0, 2203, 439, 0, 58, 0, 0, 0, 0, 1195};
        bit          ufs  [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        int          lats [11] = '{2, 4, 4, 2, 3, 4, 7, 7, 7, 6, 3};
        int          lat;
        logic [3:0]  ek;
        logic [11:0] er;
        for (int i = 0; i < 11; i++) begin
            ek = 4'(ks[i]);
            er = REM_EN ? 12'(rems[i]) : 12'd0;
            out_ready = 1'b1;
            in_scale  = 12'(xs[i]);
            in_valid  = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lookup_busy x=%0d in_ready got=%b want=0", xs[i], in_ready); end
            lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            total++; if (lat !== lats[i]) begin bad++; $display("FAIL lookup_latency x=%0d got=%0d want=%0d", xs[i], lat, lats[i]); end
            total++; if (out_int !== ek) begin bad++; $display("FAIL lookup_int x=%0d got=%h want=%h", xs[i], out_int, ek); end
            total++; if (out_rem !== er) begin bad++; $display("FAIL lookup_rem x=%0d got=%0d want=%0d", xs[i], out_rem, er); end
            total++; if (out_uflow !== ufs[i]) begin bad++; $display("FAIL lookup_uflow x=%0d got=%b want=%b", xs[i], out_uflow, ufs[i]); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lookup_release x=%0d out_valid got=%b want=0", xs[i], out_valid); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lookup_ready_back x=%0d in_ready got=%b want=1", xs[i], in_ready); end
        end
    endtask

    // x = 13 held in DONE for 5 cycles; a stray in_valid pulse must be dropped.
    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        in_scale  = 12'd13;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat !== 5) begin bad++; $display("FAIL bp_latency got=%0d want=5", lat); end
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                in_scale = 12'd4000;
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", c, out_valid); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready cyc=%0d got=%b want=0", c, in_ready); end
            total++; if (out_int !== 4'hD) begin bad++; $display("FAIL bp_hold_int cyc=%0d got=%h want=d", c, out_int); end
            total++; if (out_rem !== 12'd0) begin bad++; $display("FAIL bp_hold_rem cyc=%0d got=%0d want=0", c, out_rem); end
            total++; if (out_uflow !== 1'b0) begin bad++; $display("FAIL bp_hold_uflow cyc=%0d got=%b want=0", c, out_uflow); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_stray_accept cyc=%0d out_valid=%b in_ready=%b want 0/1", c, out_valid, in_ready); end
        end
    endtask

    // in_valid held high with x = 696 (k = 1): one result every 4 cycles.
    task automatic test_back_to_back();
        int first;
        int second;
        out_ready = 1'b1;
        in_scale  = 12'd696;
        in_valid  = 1'b1;
        first  = -1;
        second = -1;
        for (int c = 0; c < 20 && second < 0; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                total++; if (out_int !== 4'd1) begin bad++; $display("FAIL b2b_int cyc=%0d got=%h want=1", c, out_int); end
                if (first < 0) first = c;
                else second = c;
            end
        end
        in_valid = 1'b0;
        total++; if (second - first !== 4 || first < 0) begin bad++; $display("FAIL b2b_period got=%0d want=4 (first=%0d second=%0d)", second - first, first, second); end
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Reset asserted during the second SEARCH cycle of x = 4000.
    task automatic test_async_reset();
        int seen;
        int lat;
        out_ready = 1'b1;
        in_scale  = 12'd4000;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", out_valid); end
        total++; if (out_int !== 4'd0) begin bad++; $display("FAIL arst_out_int got=%h want=0", out_int); end
        total++; if (out_rem !== 12'd0) begin bad++; $display("FAIL arst_out_rem got=%0d want=0", out_rem); end
        total++; if (out_uflow !== 1'b0) begin bad++; $display("FAIL arst_out_uflow got=%b want=0", out_uflow); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL arst_no_valid got=%0d pulses want=0", seen); end
        in_scale = 12'd256;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat !== 2) begin bad++; $display("FAIL arst_next_latency got=%0d want=2", lat); end
        total++; if (out_int !== 4'd0) begin bad++; $display("FAIL arst_next_int got=%h want=0", out_int); end
        @(posedge clk); #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_scale  = 12'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_lookup();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
